// File: rtl/cosim_traffic_gen_pkg.sv
// Shared types for the cosim traffic generator/checker.
// Holds the FSM encoding and counter width used across the slice.
package Cosim_TrafficPkg;

    localparam int TOKEN_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } genState_e;

    function automatic logic [TOKEN_CNT_W-1:0] satInc(
        input logic [TOKEN_CNT_W-1:0] val,
        input logic                   inc
    );
        if (inc && (val != '1)) begin
            return val + 1'b1;
        end
        return val;
    endfunction

endpackage

// File: rtl/cosim_traffic_gen.sv
// Token generator and in-order return checker for endpoint loopback.
// Sends SEED+k tokens, bounds outstanding, compares the echoed stream.
module cosim_traffic_gen
    import Cosim_TrafficPkg::*;
#(
    parameter int TYPE_SIZE_BITS = 23,
    parameter int NUM_TOKENS = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter logic [TYPE_SIZE_BITS-1:0] SEED =
        TYPE_SIZE_BITS'(23'h000100),
    parameter int TIMEOUT = 1000
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    output logic                      DataInValid,
    input  logic                      DataInReady,
    output logic [TYPE_SIZE_BITS-1:0] DataIn,
    input  logic                      DataOutValid,
    output logic                      DataOutReady,
    input  logic [TYPE_SIZE_BITS-1:0] DataOut,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [TOKEN_CNT_W-1:0]    err_count,
    output logic [TOKEN_CNT_W-1:0]    sent_count,
    output logic [TOKEN_CNT_W-1:0]    recv_count
);

    localparam logic [TOKEN_CNT_W-1:0] NUM_TOK =
        TOKEN_CNT_W'(NUM_TOKENS);
    localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);
    localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

    genState_e state;
    genState_e stateNext;

    logic sendFire;
    logic recvFire;
    logic startHit;
    logic mismatch;
    logic timeoutHit;

    logic [TOKEN_CNT_W-1:0] sentNext;
    logic [TOKEN_CNT_W-1:0] recvNext;
    logic [7:0]             outstanding;
    logic [7:0]             outNext;
    logic [31:0]            watchdog;

    logic [TYPE_SIZE_BITS-1:0] expected;

    logic [TYPE_SIZE_BITS-1:0] dataInD;
    logic                      validD;
    logic [TOKEN_CNT_W-1:0]    sentD;
    logic [TOKEN_CNT_W-1:0]    recvD;
    logic [TOKEN_CNT_W-1:0]    errCntD;
    logic                      errD;
    logic [7:0]                outD;
    logic [31:0]               watchdogD;

    assign sendFire = DataInValid && DataInReady;
    assign recvFire = DataOutValid && DataOutReady;
    assign startHit = start && ((state == IDLE) || (state == DONE));
    assign sentNext = sent_count + TOKEN_CNT_W'(sendFire);
    assign recvNext = recv_count + TOKEN_CNT_W'(recvFire);
    assign expected = SEED + TYPE_SIZE_BITS'(recv_count);
    assign mismatch = recvFire && (DataOut != expected);

    // Watchdog only runs in DRAIN; any receive restarts the idle window.
    assign timeoutHit = (state == DRAIN) && !recvFire &&
                        ((watchdog + 32'd1) >= TIMEOUT_W);

    always_comb begin
        unique case ({sendFire, recvFire})
            2'b10:   outNext = outstanding + 8'd1;
            2'b01:   outNext = outstanding - 8'd1;
            default: outNext = outstanding;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE, DONE: begin
                if (start) stateNext = RUN;
            end
            RUN: begin
                if (sentNext == NUM_TOK) stateNext = DRAIN;
            end
            DRAIN: begin
                if ((recvNext == NUM_TOK) || timeoutHit) begin
                    stateNext = DONE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state == RUN) || (state == DRAIN);
        done         = (state == DONE);
        DataOutReady = busy && (outstanding != 8'd0);
    end

    always_comb begin
        dataInD   = DataIn;
        validD    = DataInValid;
        sentD     = sent_count;
        recvD     = recv_count;
        errCntD   = err_count;
        errD      = err;
        outD      = outstanding;
        watchdogD = watchdog;
        if (startHit) begin
            dataInD   = SEED;
            validD    = 1'b1;
            sentD     = '0;
            recvD     = '0;
            errCntD   = '0;
            errD      = 1'b0;
            outD      = '0;
            watchdogD = '0;
        end else if (busy) begin
            sentD   = sentNext;
            recvD   = recvNext;
            outD    = outNext;
            errD    = err || mismatch || timeoutHit;
            errCntD = satInc(err_count, mismatch || timeoutHit);
            if ((state == DRAIN) && !recvFire) begin
                watchdogD = watchdog + 32'd1;
            end else begin
                watchdogD = '0;
            end
            // A presented token holds until accepted.
            if (state != RUN) begin
                validD = 1'b0;
            end else if (DataInValid && !sendFire) begin
                validD = 1'b1;
            end else if ((sentNext < NUM_TOK) && (outNext < MAX_OUT)) begin
                validD  = 1'b1;
                dataInD = SEED + TYPE_SIZE_BITS'(sentNext);
            end else begin
                validD = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            DataIn      <= '0;
            DataInValid <= 1'b0;
            sent_count  <= '0;
            recv_count  <= '0;
            err_count   <= '0;
            err         <= 1'b0;
            outstanding <= '0;
            watchdog    <= '0;
        end else begin
            DataIn      <= dataInD;
            DataInValid <= validD;
            sent_count  <= sentD;
            recv_count  <= recvD;
            err_count   <= errCntD;
            err         <= errD;
            outstanding <= outD;
            watchdog    <= watchdogD;
        end
    end

endmodule

// File: tb/tb_cosim_traffic_gen.sv
// Directed bench: loopback, backpressure, withheld returns, corruption,
// timeout, mid-run reset and seed wrap-around on two configurations.
module tb_cosim_traffic_gen;

    logic clk;
    logic rstn;

    logic        aStart, aInReady, aOutValid;
    logic [22:0] aOut;
    logic        aInValid, aOutReady, aBusy, aDone, aErr;
    logic [22:0] aIn;
    logic [15:0] aErrCnt, aSent, aRecv;

    logic        bStart, bInReady, bOutValid;
    logic [22:0] bOut;
    logic        bInValid, bOutReady, bBusy, bDone, bErr;
    logic [22:0] bIn;
    logic [15:0] bErrCnt, bSent, bRecv;

    int vectors = 0;
    int miscompares = 0;

    logic [22:0] aQ[$];
    logic [22:0] aLog[$];
    logic [22:0] bQ[$];
    logic [22:0] bLog[$];

    logic rdyA = 1'b1;
    logic retEn = 1'b1;
    logic dropLast = 1'b0;
    int   corruptIdx = -1;
    int   aRecvSeen = 0;
    logic aLastRf = 1'b0;

    cosim_traffic_gen #(
        .NUM_TOKENS(4),
        .MAX_OUTSTANDING(2),
        .TIMEOUT(10)
    ) dutA (
        .clk(clk),
        .rstn(rstn),
        .start(aStart),
        .DataInValid(aInValid),
        .DataInReady(aInReady),
        .DataIn(aIn),
        .DataOutValid(aOutValid),
        .DataOutReady(aOutReady),
        .DataOut(aOut),
        .busy(aBusy),
        .done(aDone),
        .err(aErr),
        .err_count(aErrCnt),
        .sent_count(aSent),
        .recv_count(aRecv)
    );

    cosim_traffic_gen #(
        .NUM_TOKENS(2),
        .SEED(23'h7FFFFF)
    ) dutB (
        .clk(clk),
        .rstn(rstn),
        .start(bStart),
        .DataInValid(bInValid),
        .DataInReady(bInReady),
        .DataIn(bIn),
        .DataOutValid(bOutValid),
        .DataOutReady(bOutReady),
        .DataOut(bOut),
        .busy(bBusy),
        .done(bDone),
        .err(bErr),
        .err_count(bErrCnt),
        .sent_count(bSent),
        .recv_count(bRecv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] aTok(input int i);
        if (i < aLog.size()) return {9'd0, aLog[i]};
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] bTok(input int i);
        if (i < bLog.size()) return {9'd0, bLog[i]};
        return 32'hFFFF_FFFF;
    endfunction

    // One clock of the host-side endpoint model for dutA.
    task automatic stepA();
        logic sf, rf;
        logic [22:0] tok;
        @(negedge clk);
        aInReady = rdyA;
        aOutValid = retEn && (aQ.size() > 0) &&
                    !(dropLast && (aRecvSeen == 3));
        aOut = 23'h0;
        if (aOutValid) begin
            aOut = aQ[0];
            if (aRecvSeen == corruptIdx) aOut = 23'h000199;
        end
        #1;
        sf = rstn && aInValid && aInReady;
        rf = rstn && aOutValid && aOutReady;
        tok = aIn;
        @(posedge clk);
        #1;
        if (sf) begin
            aQ.push_back(tok);
            aLog.push_back(tok);
        end
        if (rf) begin
            void'(aQ.pop_front());
            aRecvSeen++;
        end
        aLastRf = rf;
    endtask

    task automatic stepB();
        logic sf, rf;
        logic [22:0] tok;
        @(negedge clk);
        bInReady = 1'b1;
        bOutValid = (bQ.size() > 0);
        bOut = 23'h0;
        if (bOutValid) bOut = bQ[0];
        #1;
        sf = rstn && bInValid && bInReady;
        rf = rstn && bOutValid && bOutReady;
        tok = bIn;
        @(posedge clk);
        #1;
        if (sf) begin
            bQ.push_back(tok);
            bLog.push_back(tok);
        end
        if (rf) void'(bQ.pop_front());
    endtask

    task automatic newRunA();
        aLog.delete();
        aQ.delete();
        aRecvSeen = 0;
        aStart = 1'b1;
        stepA();
        aStart = 1'b0;
    endtask

    task automatic runToDoneA();
        for (int i = 0; i < 100 && !aDone; i++) stepA();
    endtask

    task automatic checkResetA(input string tag);
        check({tag, "_vld"}, {31'd0, aInValid}, 32'd0);
        check({tag, "_din"}, {9'd0, aIn}, 32'd0);
        check({tag, "_busy"}, {31'd0, aBusy}, 32'd0);
        check({tag, "_done"}, {31'd0, aDone}, 32'd0);
        check({tag, "_err"}, {31'd0, aErr}, 32'd0);
        check({tag, "_ecnt"}, {16'd0, aErrCnt}, 32'd0);
        check({tag, "_sent"}, {16'd0, aSent}, 32'd0);
        check({tag, "_recv"}, {16'd0, aRecv}, 32'd0);
        check({tag, "_ordy"}, {31'd0, aOutReady}, 32'd0);
    endtask

    initial begin
        int stepIdx, lastRecvIdx, doneIdx;
        rstn = 1'b0;
        aStart = 1'b0; aInReady = 1'b0;
        aOutValid = 1'b0; aOut = 23'h0;
        bStart = 1'b0; bInReady = 1'b0;
        bOutValid = 1'b0; bOut = 23'h0;
        stepA();
        stepA();
        checkResetA("reset");
        rstn = 1'b1;
        stepA();
        check("idle_busy", {31'd0, aBusy}, 32'd0);

        // Seed wrap-around on the second instance.
        bStart = 1'b1;
        stepB();
        bStart = 1'b0;
        for (int i = 0; i < 50 && !bDone; i++) stepB();
        check("wrap_done", {31'd0, bDone}, 32'd1);
        check("wrap_cnt", {16'd0, bSent}, 32'd2);
        check("wrap_tok0", bTok(0), 32'h007F_FFFF);
        check("wrap_tok1", bTok(1), 32'h0000_0000);
        check("wrap_err", {31'd0, bErr}, 32'd0);
        check("wrap_recv", {16'd0, bRecv}, 32'd2);

        // Plain loopback echo.
        rdyA = 1'b1; retEn = 1'b1;
        newRunA();
        check("lb_first", {9'd0, aIn}, 32'h100);
        runToDoneA();
        check("lb_done", {31'd0, aDone}, 32'd1);
        check("lb_nlog", aLog.size(), 32'd4);
        check("lb_tok0", aTok(0), 32'h100);
        check("lb_tok1", aTok(1), 32'h101);
        check("lb_tok2", aTok(2), 32'h102);
        check("lb_tok3", aTok(3), 32'h103);
        check("lb_err", {31'd0, aErr}, 32'd0);
        check("lb_ecnt", {16'd0, aErrCnt}, 32'd0);
        check("lb_sent", {16'd0, aSent}, 32'd4);
        check("lb_recv", {16'd0, aRecv}, 32'd4);
        check("lb_vld", {31'd0, aInValid}, 32'd0);
        check("lb_ordy", {31'd0, aOutReady}, 32'd0);

        // Outstanding cap with withheld returns; start is ignored mid-run.
        retEn = 1'b0;
        newRunA();
        aStart = 1'b1;
        for (int i = 0; i < 6; i++) stepA();
        aStart = 1'b0;
        check("cap_nlog", aLog.size(), 32'd2);
        check("cap_tok0", aTok(0), 32'h100);
        check("cap_tok1", aTok(1), 32'h101);
        check("cap_vld", {31'd0, aInValid}, 32'd0);
        check("cap_sent", {16'd0, aSent}, 32'd2);
        check("cap_ordy", {31'd0, aOutReady}, 32'd1);
        retEn = 1'b1;
        stepA();
        check("cap_rel_vld", {31'd0, aInValid}, 32'd1);
        check("cap_rel_din", {9'd0, aIn}, 32'h102);
        runToDoneA();
        check("cap_done", {31'd0, aDone}, 32'd1);
        check("cap_recv", {16'd0, aRecv}, 32'd4);
        check("cap_err", {31'd0, aErr}, 32'd0);

        // Backpressure: token must stay put while ready is low.
        rdyA = 1'b0;
        newRunA();
        for (int i = 0; i < 5; i++) begin
            stepA();
            check("bp_din", {9'd0, aIn}, 32'h100);
            check("bp_vld", {31'd0, aInValid}, 32'd1);
        end
        check("bp_sent0", {16'd0, aSent}, 32'd0);
        rdyA = 1'b1;
        stepA();
        check("bp_sent1", {16'd0, aSent}, 32'd1);
        check("bp_nlog", aLog.size(), 32'd1);
        runToDoneA();
        check("bp_recv", {16'd0, aRecv}, 32'd4);

        // Corrupted second return.
        corruptIdx = 1;
        newRunA();
        runToDoneA();
        corruptIdx = -1;
        check("cor_done", {31'd0, aDone}, 32'd1);
        check("cor_err", {31'd0, aErr}, 32'd1);
        check("cor_ecnt", {16'd0, aErrCnt}, 32'd1);
        check("cor_recv", {16'd0, aRecv}, 32'd4);

        // Last token never returned: drain watchdog fires.
        dropLast = 1'b1;
        newRunA();
        stepIdx = 0; lastRecvIdx = -1; doneIdx = -1;
        for (int i = 0; i < 60 && !aDone; i++) begin
            stepA();
            stepIdx++;
            if (aLastRf) lastRecvIdx = stepIdx;
            if (aDone) doneIdx = stepIdx;
        end
        dropLast = 1'b0;
        check("to_done", {31'd0, aDone}, 32'd1);
        check("to_gap", doneIdx - lastRecvIdx, 32'd10);
        check("to_err", {31'd0, aErr}, 32'd1);
        check("to_ecnt", {16'd0, aErrCnt}, 32'd1);
        check("to_recv", {16'd0, aRecv}, 32'd3);
        check("to_sent", {16'd0, aSent}, 32'd4);

        // Reset mid-run, then restart from the seed.
        newRunA();
        stepA();
        stepA();
        check("mr_busy", {31'd0, aBusy}, 32'd1);
        rstn = 1'b0;
        stepA();
        checkResetA("mr");
        rstn = 1'b1;
        newRunA();
        check("mr_vld", {31'd0, aInValid}, 32'd1);
        check("mr_din", {9'd0, aIn}, 32'h100);
        runToDoneA();
        check("mr_done", {31'd0, aDone}, 32'd1);
        check("mr_tok0", aTok(0), 32'h100);
        check("mr_tok3", aTok(3), 32'h103);
        check("mr_err", {31'd0, aErr}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cosim_traffic_gen.md
COSIM_TRAFFIC_GEN -- requirements
Module: cosim_traffic_gen

Interface
REQ-001 Parameter TYPE_SIZE_BITS, default 23, token width on both channels SHALL be this value.
REQ-002 Parameter NUM_TOKENS, default 16, SHALL set the tokens sent per run (1..65535).
REQ-003 Parameter MAX_OUTSTANDING, default 4, SHALL cap sent-but-not-returned tokens (1..255).
REQ-004 Parameter SEED, default 23'h000100, SHALL set the first token value.
REQ-005 Parameter TIMEOUT, default 1000, SHALL set idle cycles tolerated in DRAIN.
REQ-006 clk  in  1  clock; all logic on rising edge.
REQ-007 rstn  in  1  reset, synchronous, active-low.
REQ-008 start  in  1  level; begins a run when sampled high in IDLE or DONE.
REQ-009 DataInValid  out  1  token toward endpoint (host-bound) valid.
REQ-010 DataInReady  in  1  endpoint accepts token.
REQ-011 DataIn  out  TYPE_SIZE_BITS  token toward endpoint.
REQ-012 DataOutValid  in  1  returned token from endpoint valid.
REQ-013 DataOutReady  out  1  generator accepts returned token.
REQ-014 DataOut  in  TYPE_SIZE_BITS  returned token.
REQ-015 busy  out  1  high in RUN or DRAIN.
REQ-016 done  out  1  high in DONE.
REQ-017 err  out  1  sticky error flag for current run.
REQ-018 err_count  out  16  mismatches plus timeout events, saturating at 16'hFFFF.
REQ-019 sent_count, recv_count  out  16 each  handshakes completed this run.

Function
REQ-020 FSM states IDLE, RUN, DRAIN, DONE; transfer on a channel SHALL occur only when valid and ready are both high at a rising edge.
REQ-021 IDLE/DONE + start: next state RUN; same edge clears counters, err, outstanding; loads DataIn=SEED, DataInValid=1.
REQ-022 Token k (0-based) SHALL equal (SEED + k) mod 2^TYPE_SIZE_BITS; wrap-around silently.
REQ-023 Once DataInValid is high, DataIn and DataInValid SHALL hold until the handshake; no retraction.
REQ-024 After a send handshake, next token SHALL be presented on the following cycle iff sent_count+1 < NUM_TOKENS and outstanding after update < MAX_OUTSTANDING; otherwise DataInValid=0 and presented when condition later holds.
REQ-025 outstanding: +1 on send only, -1 on receive only, unchanged on simultaneous send and receive.
REQ-026 DataOutReady SHALL be combinational: high iff state is RUN or DRAIN and registered outstanding != 0.
REQ-027 Each received token SHALL be compared to (SEED + recv_count) mod 2^TYPE_SIZE_BITS; mismatch sets err and increments err_count; recv_count increments regardless.
REQ-028 RUN -> DRAIN when sent_count reaches NUM_TOKENS.
REQ-029 DRAIN -> DONE when recv_count reaches NUM_TOKENS; outstanding is 0 there.
REQ-030 DRAIN: watchdog counts cycles without a receive handshake, clears on each receive; reaching TIMEOUT -> DONE, sets err, increments err_count once.
REQ-031 start while RUN or DRAIN SHALL be ignored.
REQ-032 In IDLE and DONE, DataInValid=0 and DataOutReady=0; counters retain values in DONE.

Reset
REQ-033 rstn low at a rising edge SHALL force IDLE, DataInValid=0, DataIn=0, busy=0, done=0, err=0, all counters and outstanding to 0, regardless of state or pending handshakes.
REQ-034 Reset mid-run SHALL abandon in-flight tokens; a later start SHALL begin again at SEED.

Structure
REQ-035 FSM state enum and a TOKEN_CNT_W=16 constant SHALL live in shared package Cosim_TrafficPkg.
REQ-036 Generator and checker SHALL be one module; no sub-module; instantiable beside Cosim_Endpoint with DataIn/DataOut port names matching by .* connection.

Verification
REQ-037 Loopback echo, ready always 1, NUM_TOKENS=4: tokens 000100..000103 sent, all returned, done with err=0, err_count=0, sent_count=recv_count=4.
REQ-038 MAX_OUTSTANDING=2, host withholds returns: exactly 2 sends (000100, 000101), DataInValid=0 until a return; then 000102 presented next cycle.
REQ-039 DataInReady low 5 cycles with valid high: DataIn stays 000100 stable throughout; single send counted.
REQ-040 Host corrupts 2nd return to 000199: err=1, err_count=1, run still completes to DONE with recv_count=NUM_TOKENS.
REQ-041 SEED=23'h7FFFFF, NUM_TOKENS=2: tokens 7FFFFF then 000000; no error.
REQ-042 Host never returns last token, TIMEOUT=10: DONE 10 cycles after last receive, err=1, err_count=1; rstn low mid-RUN returns all outputs to reset values next edge.
